// File: rtl/maze_player_ctrl_if.sv
// Player-controller signal bundle: button inputs, wall-lookup query port, player status.
// master = controller side, slave = debouncers/level ROM/renderer side.
interface maze_player_ctrl_if;
  logic        level_start;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic [2:0]  q_row;
  logic [3:0]  q_col;
  logic [3:0]  q_walls;
  logic [2:0]  player_row;
  logic [3:0]  player_col;
  logic        move_valid;
  logic        bump;
  logic        goal_reached;
  logic [15:0] move_count;

  modport master (
    input  level_start, btn_up, btn_down, btn_left, btn_right, q_walls,
    output q_row, q_col, player_row, player_col, move_valid, bump,
           goal_reached, move_count
  );

  modport slave (
    output level_start, btn_up, btn_down, btn_left, btn_right, q_walls,
    input  q_row, q_col, player_row, player_col, move_valid, bump,
           goal_reached, move_count
  );
endinterface

// File: rtl/maze_player_ctrl.sv
// Moves a player token one tile per button press through the level's wall ROM.
// Latency: button seen in READY -> position/move_valid/bump visible 3 cycles later.
// Backpressure: none; held buttons auto-repeat every HOLD_CYCLES of cooldown, release re-arms at once.
module maze_player_ctrl #(
  parameter int NUM_ROWS    = 5,
  parameter int NUM_COLS    = 10,
  parameter int START_ROW   = 0,
  parameter int START_COL   = 0,
  parameter int GOAL_ROW    = 4,
  parameter int GOAL_COL    = 9,
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic               clk,
  input  logic               rst,
  maze_player_ctrl_if.master bus
);

  localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [2:0] ROW_MAX = 3'(NUM_ROWS - 1);
  localparam logic [3:0] COL_MAX = 4'(NUM_COLS - 1);
  localparam logic [2:0] ROW_START = 3'(START_ROW);
  localparam logic [3:0] COL_START = 4'(START_COL);
  localparam logic [2:0] ROW_GOAL = 3'(GOAL_ROW);
  localparam logic [3:0] COL_GOAL = 4'(GOAL_COL);

  typedef enum logic [2:0] {IDLE, READY, LOOKUP, DECIDE, COOLDOWN, WON} state_t;
  // Encoding doubles as the bit index into the {T,B,L,R} wall nibble.
  typedef enum logic [1:0] {DIR_R = 2'd0, DIR_L = 2'd1, DIR_D = 2'd2, DIR_U = 2'd3} dir_t;

  state_t        state_r, state_n;
  dir_t          dir_r, dir_n;
  logic [3:0]    wall_r, wall_n;
  logic [2:0]    row_r, row_n, tgt_row;
  logic [3:0]    col_r, col_n, tgt_col;
  logic [CW-1:0] cnt_r, cnt_n;
  logic [15:0]   move_count_r, count_n;
  logic          goal_r, goal_n;
  logic          move_valid_r, move_valid_n;
  logic          bump_r, bump_n;
  logic          blocked;
  logic          any_btn;

  assign any_btn = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      dir_r        <= DIR_R;
      wall_r       <= '0;
      row_r        <= ROW_START;
      col_r        <= COL_START;
      cnt_r        <= '0;
      move_count_r <= '0;
      goal_r       <= 1'b0;
      move_valid_r <= 1'b0;
      bump_r       <= 1'b0;
    end else begin
      state_r      <= state_n;
      dir_r        <= dir_n;
      wall_r       <= wall_n;
      row_r        <= row_n;
      col_r        <= col_n;
      cnt_r        <= cnt_n;
      move_count_r <= count_n;
      goal_r       <= goal_n;
      move_valid_r <= move_valid_n;
      bump_r       <= bump_n;
    end
  end

  always_comb begin
    state_n      = state_r;
    dir_n        = dir_r;
    wall_n       = wall_r;
    row_n        = row_r;
    col_n        = col_r;
    cnt_n        = cnt_r;
    count_n      = move_count_r;
    goal_n       = goal_r;
    move_valid_n = 1'b0;
    bump_n       = 1'b0;
    blocked      = 1'b0;
    tgt_row      = row_r;
    tgt_col      = col_r;

    case (state_r)
      READY: begin
        if (any_btn) begin
          if (bus.btn_up)        dir_n = DIR_U;
          else if (bus.btn_down) dir_n = DIR_D;
          else if (bus.btn_left) dir_n = DIR_L;
          else                   dir_n = DIR_R;
          state_n = LOOKUP;
        end
      end
      LOOKUP: begin
        wall_n  = bus.q_walls;
        state_n = DECIDE;
      end
      DECIDE: begin
        // Edge test keeps indices in range even when the maze lacks a border wall.
        case (dir_r)
          DIR_U: begin
            blocked = wall_r[DIR_U] || (row_r == 3'd0);
            if (!blocked) tgt_row = row_r - 3'd1;
          end
          DIR_D: begin
            blocked = wall_r[DIR_D] || (row_r == ROW_MAX);
            if (!blocked) tgt_row = row_r + 3'd1;
          end
          DIR_L: begin
            blocked = wall_r[DIR_L] || (col_r == 4'd0);
            if (!blocked) tgt_col = col_r - 4'd1;
          end
          default: begin
            blocked = wall_r[DIR_R] || (col_r == COL_MAX);
            if (!blocked) tgt_col = col_r + 4'd1;
          end
        endcase
        cnt_n   = CNT_LOAD;
        state_n = COOLDOWN;
        if (blocked) begin
          bump_n = 1'b1;
        end else begin
          row_n        = tgt_row;
          col_n        = tgt_col;
          move_valid_n = 1'b1;
          if (move_count_r != 16'hFFFF) count_n = move_count_r + 16'd1;
          if ((tgt_row == ROW_GOAL) && (tgt_col == COL_GOAL)) begin
            goal_n  = 1'b1;
            state_n = WON;
          end
        end
      end
      COOLDOWN: begin
        if (!any_btn || (cnt_r == '0)) state_n = READY;
        else                           cnt_n   = cnt_r - CW'(1);
      end
      IDLE, WON: ;
      default: state_n = IDLE;
    endcase

    if (bus.level_start) begin
      state_n      = READY;
      dir_n        = DIR_R;
      row_n        = ROW_START;
      col_n        = COL_START;
      cnt_n        = '0;
      count_n      = '0;
      goal_n       = 1'b0;
      move_valid_n = 1'b0;
      bump_n       = 1'b0;
    end
  end

  assign bus.q_row        = row_r;
  assign bus.q_col        = col_r;
  assign bus.player_row   = row_r;
  assign bus.player_col   = col_r;
  assign bus.move_valid   = move_valid_r;
  assign bus.bump         = bump_r;
  assign bus.goal_reached = goal_r;
  assign bus.move_count   = move_count_r;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Directed and randomized moves through a bench-held wall map, checked against a tile-level model.
module tb_maze_player_ctrl;
  localparam int NR = 5, NC = 10, SR = 0, SC = 0, GR = 0, GC = 2, HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maze_player_ctrl_if bus();
  logic [3:0] wmap [0:127];
  assign bus.q_walls = wmap[int'(bus.q_row) * NC + int'(bus.q_col)];

  maze_player_ctrl #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .START_ROW(SR), .START_COL(SC),
    .GOAL_ROW(GR), .GOAL_COL(GC), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0, errors = 0;
  int mr, mc, mcnt;
  bit mgoal;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    bus.btn_up = b[3]; bus.btn_down = b[2]; bus.btn_left = b[1]; bus.btn_right = b[0];
  endtask

  task automatic check_pos(input string tag);
    check({tag, "_row"},   32'(bus.player_row),   32'(mr));
    check({tag, "_col"},   32'(bus.player_col),   32'(mc));
    check({tag, "_qrow"},  32'(bus.q_row),        32'(mr));
    check({tag, "_qcol"},  32'(bus.q_col),        32'(mc));
    check({tag, "_count"}, 32'(bus.move_count),   32'(mcnt));
    check({tag, "_goal"},  32'(bus.goal_reached), 32'(mgoal));
  endtask

  // Model: the chosen tile move, allowed unless a wall or the grid edge stops it.
  task automatic predict(input logic [3:0] b, output int nr, output int nc, output bit ok);
    int d;
    d  = b[3] ? 3 : (b[2] ? 2 : (b[1] ? 1 : 0));
    nr = mr; nc = mc;
    if (d == 3) nr = mr - 1;
    if (d == 2) nr = mr + 1;
    if (d == 1) nc = mc - 1;
    if (d == 0) nc = mc + 1;
    ok = (wmap[mr * NC + mc][d] == 1'b0) && nr >= 0 && nr < NR && nc >= 0 && nc < NC;
  endtask

  task automatic accept(input int nr, input int nc);
    mr = nr; mc = nc;
    mcnt = (mcnt == 65535) ? 65535 : mcnt + 1;
    if (mr == GR && mc == GC) mgoal = 1'b1;
  endtask

  task automatic wait_pulse(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!(bus.move_valid || bus.bump) && lat < 20);
  endtask

  // Called at a negedge with the DUT in READY (or WON); returns at a negedge, buttons released.
  task automatic do_move(input logic [3:0] b, input string tag);
    int nr, nc, lat;
    bit ok;
    predict(b, nr, nc, ok);
    set_btn(b);
    wait_pulse(lat);
    if (mgoal) begin
      check({tag, "_won_nopulse"}, 32'(bus.move_valid | bus.bump), 32'd0);
    end else begin
      check({tag, "_lat"},  32'(lat),            32'd3);
      check({tag, "_mv"},   32'(bus.move_valid), 32'(ok));
      check({tag, "_bump"}, 32'(bus.bump),       32'(!ok));
      if (ok) accept(nr, nc);
    end
    check_pos(tag);
    set_btn(4'b0000);
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(bus.move_valid | bus.bump), 32'd0);
  endtask

  task automatic do_level_start(input string tag);
    bus.level_start = 1'b1;
    @(negedge clk);
    bus.level_start = 1'b0;
    mr = SR; mc = SC; mcnt = 0; mgoal = 1'b0;
    check({tag, "_pulses"}, 32'(bus.move_valid | bus.bump), 32'd0);
    check_pos(tag);
  endtask

  initial begin
    int lat;
    logic [3:0] b;
    for (int i = 0; i < 128; i++) wmap[i] = 4'b0000;
    wmap[0] = 4'b1110;
    wmap[1] = 4'b1100;
    bus.level_start = 1'b0;
    set_btn(4'b0000);
    mr = SR; mc = SC; mcnt = 0; mgoal = 1'b0;

    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_mv",   32'(bus.move_valid), 32'd0);
    check("rst_bump", 32'(bus.bump),       32'd0);
    check_pos("rst");
    rst = 1'b0;

    // Buttons in IDLE are ignored.
    set_btn(4'b0001);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("idle_nopulse", 32'(bus.move_valid | bus.bump), 32'd0);
    end
    check_pos("idle");
    set_btn(4'b0000);

    do_level_start("ls0");
    do_move(4'b1000, "up_edge_wall");
    do_move(4'b0100, "down_wall");
    do_move(4'b0001, "right_open");
    do_move(4'b0001, "right_goal");
    check("goal_set", 32'(bus.goal_reached), 32'd1);
    do_move(4'b0001, "won_ignored");
    do_level_start("ls1");

    // Hold down+left: down wins, repeats after a full cooldown.
    wmap[0] = 4'b0000;
    set_btn(4'b0110);
    wait_pulse(lat);
    check("hold1_lat", 32'(lat), 32'd3);
    check("hold1_mv",  32'(bus.move_valid), 32'd1);
    accept(mr + 1, mc);
    check_pos("hold1");
    wait_pulse(lat);
    check("hold2_lat", 32'(lat), 32'(HOLD + 3));
    check("hold2_mv",  32'(bus.move_valid), 32'd1);
    accept(mr + 1, mc);
    check_pos("hold2");
    set_btn(4'b0000);
    @(negedge clk);

    do_move(4'b0100, "down3");
    do_move(4'b0100, "down4");
    do_move(4'b0100, "bottom_edge");
    do_move(4'b0010, "left_edge");
    for (int i = 0; i < 9; i++) do_move(4'b0001, "row4_right");
    do_move(4'b0001, "right_edge");

    // level_start while DECIDE is committing discards the move.
    do_level_start("ls2");
    set_btn(4'b0001);
    @(negedge clk); @(negedge clk);
    bus.level_start = 1'b1;
    set_btn(4'b0000);
    @(negedge clk);
    bus.level_start = 1'b0;
    check("abort_mv",   32'(bus.move_valid), 32'd0);
    check("abort_bump", 32'(bus.bump),       32'd0);
    check_pos("abort");
    @(negedge clk);
    check("abort_late_mv", 32'(bus.move_valid | bus.bump), 32'd0);
    check_pos("abort_late");

    force dut.move_count_r = 16'hFFFF;
    @(negedge clk);
    release dut.move_count_r;
    mcnt = 65535;
    @(negedge clk);
    check("sat_preset", 32'(bus.move_count), 32'hFFFF);
    do_move(4'b0100, "sat_move");

    // Random maze and button combinations.
    do_level_start("ls_rand");
    for (int i = 0; i < NR * NC; i++) wmap[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 120; i++) begin
      b = 4'($urandom_range(1, 15));
      do_move(b, "rand");
      if (mgoal) begin
        do_move(4'($urandom_range(1, 15)), "rand_won");
        do_level_start("rand_ls");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
